maxpool2d: RTL and testbench

- Streaming 2x2, stride-2 max-pooling stage with optional ReLU.
- Sits directly downstream of the conv2d stage and consumes its Q8.8 signed feature map one element per beat.
- Emits the pooled map one element per beat to the next layer.
- Uses a valid/ready handshake on both sides and buffers one row of partial maxima internally.

---
 rtl/cnn_pkg.sv | 9 +
 rtl/maxpool2d_rowbuf.sv | 20 ++
 rtl/maxpool2d.sv | 80 ++++++++
 tb/tb_maxpool2d.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared Q8.8 element type and signed max helper for the CNN pipeline stages.
package cnn_pkg;
    localparam int DATA_W = 16;
    localparam int FRAC_BITS = 8;
    typedef logic signed [DATA_W-1:0] data_t;
    function automatic data_t smax(input data_t a, input data_t b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/maxpool2d_rowbuf.sv
// pool_rowbuf: simple-dual-port register array holding one row of horizontal maxima.
// Asynchronous read so the odd-row beat can combine with its partner in the same cycle.
module pool_rowbuf
    import cnn_pkg::*;
#(
    parameter int DEPTH = 31,
    parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  data_t         wdata,
    input  logic [AW-1:0] raddr,
    output data_t         rdata
);
    data_t mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/maxpool2d.sv
// maxpool2d: streaming 2x2 stride-2 max pool with optional ReLU over channel-major frames.
module maxpool2d
    import cnn_pkg::*;
#(
    parameter int IN_WIDTH = 62,
    parameter int IN_HEIGHT = 62,
    parameter int NUM_CHANNELS = 30,
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     frame_done
);
    localparam int OUT_W = IN_WIDTH / 2;
    localparam int OUT_H = IN_HEIGHT / 2;
    localparam int XW = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
    localparam int YW = IN_HEIGHT > 1 ? $clog2(IN_HEIGHT) : 1;
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int AW = OUT_W > 1 ? $clog2(OUT_W) : 1;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    data_t hold, hmax, rd, pooled, res;
    logic acc, x_end, y_end, c_end, skip, wr, ld, last, out_last;
    always_comb begin
        in_ready = !out_valid || out_ready;
        acc = in_valid && in_ready;
        x_end = x == XW'(IN_WIDTH - 1);
        y_end = y == YW'(IN_HEIGHT - 1);
        c_end = c == CW'(NUM_CHANNELS - 1);
        // trailing column/row of an odd dimension has no 2x2 partner
        skip = (IN_WIDTH % 2 == 1 && x_end) || (IN_HEIGHT % 2 == 1 && y_end);
        hmax = smax(hold, in_data);
        pooled = smax(rd, hmax);
        res = (RELU_EN && pooled < 0) ? '0 : pooled;
        wr = acc && x[0] && !y[0] && !skip;
        ld = acc && x[0] && y[0] && !skip;
        last = c_end && y == YW'(2 * OUT_H - 1) && x == XW'(2 * OUT_W - 1);
    end
    pool_rowbuf #(.DEPTH(OUT_W), .AW(AW)) u_rowbuf (
        .clk(clk),
        .we(wr),
        .waddr(AW'(x >> 1)),
        .wdata(hmax),
        .raddr(AW'(x >> 1)),
        .rdata(rd)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
            c <= '0;
            hold <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            if (acc) begin
                x <= x_end ? '0 : x + XW'(1);
                if (x_end) y <= y_end ? '0 : y + YW'(1);
                if (x_end && y_end) c <= c_end ? '0 : c + CW'(1);
                if (!x[0]) hold <= in_data;
            end
            if (ld) begin
                out_valid <= 1'b1;
                out_data <= res;
                out_last <= last;
            end else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_maxpool2d.sv
// tb_maxpool2d: randomized and directed checks of maxpool2d against a frame-level reference model.
module tb_maxpool2d;
    logic clk = 1'b0;
    logic reset, in_valid, out_ready;
    logic signed [15:0] in_data;
    int sel;
    logic [4:0] ir, ov, fd;
    logic signed [15:0] od [5];
    logic in_ready, out_valid, frame_done;
    logic signed [15:0] out_data;
    int tests = 0, fails = 0, fd_total = 0;
    int stim[$];
    int expq[$];
    always #5 clk = ~clk;
    always_comb begin
        in_ready = ir[sel];
        out_valid = ov[sel];
        frame_done = fd[sel];
        out_data = od[sel];
    end
    always @(negedge clk) if (frame_done === 1'b1) fd_total++;

    maxpool2d #(.IN_WIDTH(4), .IN_HEIGHT(4), .NUM_CHANNELS(1), .DATA_W(16), .RELU_EN(1'b0)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel == 0), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .frame_done(fd[0]));
    maxpool2d #(.IN_WIDTH(2), .IN_HEIGHT(2), .NUM_CHANNELS(1), .DATA_W(16), .RELU_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel == 1), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .frame_done(fd[1]));
    maxpool2d #(.IN_WIDTH(2), .IN_HEIGHT(2), .NUM_CHANNELS(1), .DATA_W(16), .RELU_EN(1'b0)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .frame_done(fd[2]));
    maxpool2d #(.IN_WIDTH(5), .IN_HEIGHT(3), .NUM_CHANNELS(1), .DATA_W(16), .RELU_EN(1'b0)) u3 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel == 3), .in_ready(ir[3]), .in_data(in_data),
        .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .frame_done(fd[3]));
    maxpool2d #(.IN_WIDTH(62), .IN_HEIGHT(62), .NUM_CHANNELS(3), .DATA_W(16), .RELU_EN(1'b1)) u4 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel == 4), .in_ready(ir[4]), .in_data(in_data),
        .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]), .frame_done(fd[4]));

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0 random, 1 counting 1.., 2 negative pattern, 3 small values with 1000 on the trailing col/row
    task automatic add_frame(input int w, input int h, input int nc, input bit relu, input int mode);
        int d[];
        int neg[4] = '{-256, -512, -1, -32768};
        d = new[w * h * nc];
        for (int i = 0; i < w * h * nc; i++) begin
            int px = i % w, py = (i / w) % h;
            case (mode)
                1: d[i] = i + 1;
                2: d[i] = neg[i % 4];
                3: d[i] = (px == w - 1 || py == h - 1) ? 1000 : int'($urandom_range(0, 7));
                default: d[i] = ($urandom_range(0, 15) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            endcase
            stim.push_back(d[i]);
        end
        for (int ch = 0; ch < nc; ch++)
            for (int oy = 0; oy < h / 2; oy++)
                for (int ox = 0; ox < w / 2; ox++) begin
                    int b = (ch * h + 2 * oy) * w + 2 * ox;
                    int m = d[b];
                    if (d[b + 1] > m) m = d[b + 1];
                    if (d[b + w] > m) m = d[b + w];
                    if (d[b + w + 1] > m) m = d[b + w + 1];
                    if (relu && m < 0) m = 0;
                    expq.push_back(m);
                end
    endtask

    task automatic run(input int exp_fd, input bit rnd, input bit stall, input int limit);
        int n_in = 0, cyc = 0;
        bit stalled = 0, acc_in, acc_out;
        logic signed [15:0] held;
        fd_total = 0;
        while ((stim.size() > 0 || expq.size() > 0) && (limit < 0 || n_in < limit) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = stim.size() > 0;
            in_data = in_valid ? 16'(stim[0]) : 16'sd0;
            #1;
            if (stall && !stalled && out_valid) begin
                stalled = 1;
                out_ready = 1'b0;
                held = out_data;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_out_data", out_data, held);
                    @(negedge clk);
                    cyc++;
                end
                out_ready = 1'b1;
                #1;
            end
            acc_in = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                if (expq.size() == 0) check("extra_output", out_data, 32'h7fffffff);
                else check("out_data", out_data, expq.pop_front());
            end
            @(posedge clk);
            if (acc_in) begin
                void'(stim.pop_front());
                n_in++;
            end
        end
        check("no_timeout", cyc < 60000, 1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (limit < 0) repeat (4) @(negedge clk);
        check("frame_done_count", fd_total, exp_fd);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_data = '0;
        sel = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sel = k;
            #1;
            check("reset_in_ready", in_ready, 1);
            check("reset_out_valid", out_valid, 0);
            check("reset_out_data", out_data, 0);
            check("reset_frame_done", frame_done, 0);
        end
        @(negedge clk);
        sel = 0; add_frame(4, 4, 1, 0, 1); run(1, 0, 0, -1);
        sel = 1; add_frame(2, 2, 1, 1, 2); run(1, 0, 0, -1);
        sel = 2; add_frame(2, 2, 1, 0, 2); run(1, 0, 0, -1);
        sel = 3; add_frame(5, 3, 1, 0, 3); add_frame(5, 3, 1, 0, 3); run(2, 1, 0, -1);
        sel = 0; add_frame(4, 4, 1, 0, 0); add_frame(4, 4, 1, 0, 0); run(2, 1, 1, -1);
        sel = 4; add_frame(62, 62, 3, 1, 0); add_frame(62, 62, 3, 1, 0); run(2, 1, 0, -1);
        sel = 0;
        repeat (3) add_frame(4, 4, 1, 0, 0);
        run(2, 0, 0, 37);
        reset = 1'b1;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_frame_done", frame_done, 0);
        check("midreset_out_data", out_data, 0);
        check("midreset_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        stim.delete();
        expq.delete();
        add_frame(4, 4, 1, 0, 1);
        run(1, 0, 0, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
